// File: rtl/zvc_pkg.sv
// ---------------------------------------------------------------------------
// zvc_pkg
// Shared definitions for the zero-value compressor / decompressor pair on the
// LIFM datapath: default geometry, derived index/count widths and the word,
// mapping-table-entry and index types.
// ---------------------------------------------------------------------------
package zvc_pkg;

    localparam int DEFAULT_WORD_WIDTH    = 8;
    localparam int DEFAULT_LINE_SIZE     = 32;
    localparam int DEFAULT_DIST_WIDTH    = 7;
    localparam int DEFAULT_MAX_LIFM_RSIZ = 3;

    // Gather index into a line, and a popcount that can reach LINE_SIZE.
    localparam int IDX_WIDTH = $clog2(DEFAULT_LINE_SIZE);
    localparam int CNT_WIDTH = $clog2(DEFAULT_LINE_SIZE + 1);

    // One mapping-table entry holds all distance fields belonging to a word.
    localparam int MT_ENTRY_WIDTH = DEFAULT_DIST_WIDTH * DEFAULT_MAX_LIFM_RSIZ;

    typedef logic [DEFAULT_WORD_WIDTH-1:0] word_t;
    typedef logic [MT_ENTRY_WIDTH-1:0]     mt_entry_t;
    typedef logic [IDX_WIDTH-1:0]          idx_t;
    typedef logic [CNT_WIDTH-1:0]          cnt_t;

endpackage : zvc_pkg

// File: rtl/zv_prefix_count.sv
// ---------------------------------------------------------------------------
// zv_prefix_count
// Combinational exclusive prefix popcount over a LINE_SIZE-bit mask.
// idx_o[i] = number of set bits in mask_i[i-1:0] (idx_o[0] = 0);
// total_o  = number of set bits in the whole mask.
//
// Ports:
//   mask_i   in  LINE_SIZE               mask to count
//   idx_o    out LINE_SIZE x IDX_W       exclusive prefix count per position
//   total_o  out CNT_W                   full popcount
// ---------------------------------------------------------------------------
module zv_prefix_count #(
    parameter int LINE_SIZE = zvc_pkg::DEFAULT_LINE_SIZE,
    parameter int IDX_W     = $clog2(LINE_SIZE),
    parameter int CNT_W     = $clog2(LINE_SIZE + 1)
) (
    input  logic [LINE_SIZE-1:0]            mask_i,
    output logic [LINE_SIZE-1:0][IDX_W-1:0] idx_o,
    output logic [CNT_W-1:0]                total_o
);

    // run[i] = popcount(mask_i[i-1:0]); a simple ripple chain is plenty for
    // a 32-entry line and keeps the structure obvious.
    logic [CNT_W-1:0] run [0:LINE_SIZE];

    assign run[0] = '0;

    for (genvar i = 0; i < LINE_SIZE; i++) begin : g_run
        assign run[i+1] = run[i] + CNT_W'(mask_i[i]);
        // run[i] <= LINE_SIZE-1 for i < LINE_SIZE, so the truncation is exact.
        assign idx_o[i] = run[i][IDX_W-1:0];
    end

    assign total_o = run[LINE_SIZE];

endmodule : zv_prefix_count

// File: rtl/zv_decompressor.sv
// ---------------------------------------------------------------------------
// zv_decompressor
// Re-expands a zero-value-compressed LIFM line (nonzero words packed at low
// indices plus a nonzero bitmask) back to original word positions, zeros in
// every masked-off slot. Mapping-table entries are expanded identically.
// Two pipeline stages, one line per cycle:
//   S1 registers mask/data and the per-position gather index.
//   S2 registers the gathered output line.
//
// Optional feature macro: ZVD_MT_EN
//   defined   -> mapping-table path built, mt_vec carries expanded entries
//   undefined -> mt_comp ignored, no mt registers, mt_vec tied to 0
//
// Handshake: a line moves across an interface on a cycle where valid and
// ready are both high at the rising edge. valid, once raised by the producer
// side of this block, holds with stable data until accepted; in_ready is the
// only combinational output (from out_ready and the stage valid flags).
//
// Ports:
//   clk        in  1                 clock, rising edge
//   reset_n    in  1                 asynchronous active-low reset
//   in_valid   in  1                 input line valid
//   in_ready   out 1                 a line can be accepted this cycle
//   lifm_comp  in  LINE_SIZE*WW      packed nonzero words
//   mt_comp    in  LINE_SIZE*MT      packed mapping-table entries
//   nz_mask    in  LINE_SIZE         bit i set = original word i nonzero
//   out_valid  out 1                 expanded line valid
//   out_ready  in  1                 consumer accepts the line
//   lifm_vec   out LINE_SIZE*WW      expanded line
//   mt_vec     out LINE_SIZE*MT      expanded mapping table
//   nz_cnt     out CNT_W             popcount of the output line's mask
// ---------------------------------------------------------------------------
module zv_decompressor
    import zvc_pkg::*;
#(
    parameter int WORD_WIDTH    = DEFAULT_WORD_WIDTH,
    parameter int LINE_SIZE     = DEFAULT_LINE_SIZE,
    parameter int DIST_WIDTH    = DEFAULT_DIST_WIDTH,
    parameter int MAX_LIFM_RSIZ = DEFAULT_MAX_LIFM_RSIZ
) (
    input  logic                                          clk,
    input  logic                                          reset_n,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic [LINE_SIZE*WORD_WIDTH-1:0]               lifm_comp,
    input  logic [LINE_SIZE*DIST_WIDTH*MAX_LIFM_RSIZ-1:0] mt_comp,
    input  logic [LINE_SIZE-1:0]                          nz_mask,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [LINE_SIZE*WORD_WIDTH-1:0]               lifm_vec,
    output logic [LINE_SIZE*DIST_WIDTH*MAX_LIFM_RSIZ-1:0] mt_vec,
    output logic [$clog2(LINE_SIZE+1)-1:0]                nz_cnt
);

    localparam int IDX_W = $clog2(LINE_SIZE);
    localparam int CNT_W = $clog2(LINE_SIZE + 1);
    localparam int LW    = LINE_SIZE * WORD_WIDTH;
    localparam int MTE   = DIST_WIDTH * MAX_LIFM_RSIZ;

    // ---------------- handshake ----------------
    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic s1_load, s2_load;

    assign s2_load  = !s2_valid_q || out_ready;
    assign s1_load  = !s1_valid_q || s2_load;
    assign in_ready = s1_load;

    // S1 refills (or empties) whenever it may load; S2 takes whatever S1 holds.
    assign s1_valid_d = s1_load ? in_valid   : s1_valid_q;
    assign s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;

    // Data registers only capture on a real transfer so that stale content
    // never shifts through on bubbles and held outputs stay stable.
    logic s1_cap, s2_cap;
    assign s1_cap = s1_load && in_valid;
    assign s2_cap = s2_load && s1_valid_q;

    // ---------------- stage 1 ----------------
    logic [LINE_SIZE-1:0]            s1_mask_q;
    logic [LW-1:0]                   s1_lifm_q;
    logic [LINE_SIZE-1:0][IDX_W-1:0] s1_idx_q;
    logic [CNT_W-1:0]                s1_cnt_q;

    logic [LINE_SIZE-1:0][IDX_W-1:0] pc_idx;
    logic [CNT_W-1:0]                pc_total;

    zv_prefix_count #(
        .LINE_SIZE (LINE_SIZE),
        .IDX_W     (IDX_W),
        .CNT_W     (CNT_W)
    ) u_prefix (
        .mask_i  (nz_mask),
        .idx_o   (pc_idx),
        .total_o (pc_total)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_mask_q <= '0;
            s1_lifm_q <= '0;
            s1_idx_q  <= '0;
            s1_cnt_q  <= '0;
        end else if (s1_cap) begin
            s1_mask_q <= nz_mask;
            s1_lifm_q <= lifm_comp;
            s1_idx_q  <= pc_idx;
            s1_cnt_q  <= pc_total;
        end
    end

    // ---------------- stage 2: gather ----------------
    // Masked-off slots are forced to zero, so packed words beyond the
    // popcount can never reach the output.
    logic [LW-1:0] gath_lifm;

    always_comb begin
        gath_lifm = '0;
        for (int i = 0; i < LINE_SIZE; i++) begin
            if (s1_mask_q[i]) begin
                gath_lifm[i*WORD_WIDTH +: WORD_WIDTH] =
                    s1_lifm_q[s1_idx_q[i]*WORD_WIDTH +: WORD_WIDTH];
            end
        end
    end

    logic [LW-1:0]    lifm_vec_q;
    logic [CNT_W-1:0] nz_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lifm_vec_q <= '0;
            nz_cnt_q   <= '0;
        end else if (s2_cap) begin
            lifm_vec_q <= gath_lifm;
            nz_cnt_q   <= s1_cnt_q;
        end
    end

    assign out_valid = s2_valid_q;
    assign lifm_vec  = lifm_vec_q;
    assign nz_cnt    = nz_cnt_q;

    // ---------------- mapping-table path ----------------
`ifdef ZVD_MT_EN
    logic [LINE_SIZE*MTE-1:0] s1_mt_q;
    logic [LINE_SIZE*MTE-1:0] gath_mt;
    logic [LINE_SIZE*MTE-1:0] mt_vec_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_mt_q <= '0;
        end else if (s1_cap) begin
            s1_mt_q <= mt_comp;
        end
    end

    always_comb begin
        gath_mt = '0;
        for (int i = 0; i < LINE_SIZE; i++) begin
            if (s1_mask_q[i]) begin
                gath_mt[i*MTE +: MTE] = s1_mt_q[s1_idx_q[i]*MTE +: MTE];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mt_vec_q <= '0;
        end else if (s2_cap) begin
            mt_vec_q <= gath_mt;
        end
    end

    assign mt_vec = mt_vec_q;
`else
    // Mapping table disabled: input is intentionally discarded.
    logic unused_mt_comp;
    assign unused_mt_comp = ^mt_comp;
    assign mt_vec         = '0;
`endif

endmodule : zv_decompressor

// File: tb/tb_zv_decompressor.sv
module tb_zv_decompressor;

  localparam int WW  = 8;
  localparam int LS  = 32;
  localparam int MTE = 7 * 3;
  localparam int LW  = LS * WW;
  localparam int MW  = LS * MTE;
  localparam int CW  = $clog2(LS + 1);

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT ----------------
  logic          in_valid;
  logic          in_ready;
  logic [LW-1:0] lifm_comp;
  logic [MW-1:0] mt_comp;
  logic [LS-1:0] nz_mask;
  logic          out_valid;
  logic          out_ready;
  logic [LW-1:0] lifm_vec;
  logic [MW-1:0] mt_vec;
  logic [CW-1:0] nz_cnt;

  zv_decompressor dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .lifm_comp (lifm_comp),
    .mt_comp   (mt_comp),
    .nz_mask   (nz_mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .lifm_vec  (lifm_vec),
    .mt_vec    (mt_vec),
    .nz_cnt    (nz_cnt)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit lat_mode = 1'b1;

  logic [LW-1:0] exp_q[$];
  logic [MW-1:0] exp_mt_q[$];
  logic [CW-1:0] exp_cnt_q[$];
  int            acc_cyc_q[$];

  task automatic check(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Reference expansion: walk the mask, handing out packed words in order.
  task automatic expand(input logic [LS-1:0] m, input logic [LW-1:0] lc, input logic [MW-1:0] mc,
                        output logic [LW-1:0] lv, output logic [MW-1:0] mv, output logic [CW-1:0] cnt);
    int k;
    k  = 0;
    lv = '0;
    mv = '0;
    for (int i = 0; i < LS; i++) begin
      if (m[i]) begin
        lv[i*WW +: WW] = lc[k*WW +: WW];
        mv[i*MTE +: MTE] = mc[k*MTE +: MTE];
        k++;
      end
    end
`ifndef ZVD_MT_EN
    mv = '0;
`endif
    cnt = CW'(k);
  endtask

  // ---------------- driver ----------------
  // Called at posedge+1; drives inputs, evaluates transfers for the coming
  // edge, then advances to the next posedge+1.
  task automatic cycle(input logic iv, input logic [LS-1:0] m, input logic [LW-1:0] lc,
                       input logic [MW-1:0] mc, input logic ordy, output logic acc);
    logic [LW-1:0] lv;
    logic [MW-1:0] mv;
    logic [CW-1:0] cv;
    in_valid  = iv;
    nz_mask   = m;
    lifm_comp = lc;
    mt_comp   = mc;
    out_ready = ordy;
    #1;
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", MW'(out_valid), '0);
      end else begin
        lv = exp_q.pop_front();
        mv = exp_mt_q.pop_front();
        cv = exp_cnt_q.pop_front();
        check("lifm_vec", MW'(lifm_vec), MW'(lv));
        check("mt_vec", mt_vec, mv);
        check("nz_cnt", MW'(nz_cnt), MW'(cv));
        if (lat_mode) check("latency", MW'(cyc - acc_cyc_q[0]), MW'(2));
        void'(acc_cyc_q.pop_front());
      end
    end
    if (acc) begin
      expand(m, lc, mc, lv, mv, cv);
      exp_q.push_back(lv);
      exp_mt_q.push_back(mv);
      exp_cnt_q.push_back(cv);
      acc_cyc_q.push_back(cyc);
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic send(input logic [LS-1:0] m, input logic [LW-1:0] lc, input logic [MW-1:0] mc,
                      input logic ordy);
    logic acc;
    acc = 1'b0;
    for (int t = 0; t < 20 && !acc; t++) cycle(1'b1, m, lc, mc, ordy, acc);
    if (!acc) check("send_timeout", MW'(acc), MW'(1));
  endtask

  task automatic drain();
    logic acc;
    for (int t = 0; t < 20 && exp_q.size() != 0; t++) cycle(1'b0, '0, '0, '0, 1'b1, acc);
    for (int t = 0; t < 3; t++) cycle(1'b0, '0, '0, '0, 1'b1, acc);
    check("drain_empty", MW'(exp_q.size()), '0);
  endtask

  task automatic rand_line(output logic [LS-1:0] m, output logic [LW-1:0] lc, output logic [MW-1:0] mc);
    m = $urandom;
    for (int j = 0; j < LW / 32; j++) lc[j*32 +: 32] = $urandom;
    for (int j = 0; j < MW / 32; j++) mc[j*32 +: 32] = $urandom;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [LS-1:0] m;
    logic [LW-1:0] lc, lc2;
    logic [MW-1:0] mc, mc2;
    logic [LS-1:0] m2;
    logic          acc;

    in_valid  = 1'b0;
    out_ready = 1'b0;
    nz_mask   = '0;
    lifm_comp = '0;
    mt_comp   = '0;
    reset_n   = 1'b1;
    #3 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", MW'(out_valid), '0);
    check("rst_lifm_vec", MW'(lifm_vec), '0);
    check("rst_mt_vec", mt_vec, '0);
    check("rst_nz_cnt", MW'(nz_cnt), '0);
    check("rst_in_ready", MW'(in_ready), MW'(1));
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // All-ones mask, word k = k.
    for (int k = 0; k < LS; k++) begin
      lc[k*WW +: WW]   = WW'(k);
      mc[k*MTE +: MTE] = MTE'(k * 3 + 1);
    end
    send('1, lc, mc, 1'b1);
    drain();

    // Mask 0 with all-ones packed data: nothing may leak.
    send('0, '1, '1, 1'b1);
    drain();

    // Only first and last positions nonzero.
    lc = {LS{8'h55}};
    lc[0 +: WW]  = 8'hAA;
    lc[WW +: WW] = 8'hBB;
    mc = {LS{21'h155555}};
    mc[0 +: MTE]   = 21'h1AAAAA;
    mc[MTE +: MTE] = 21'h0BBBBB;
    send(32'h8000_0001, lc, mc, 1'b1);
    drain();

    // 8 random lines back-to-back; latency 2 on each means no bubbles.
    for (int n = 0; n < 8; n++) begin
      rand_line(m, lc, mc);
      send(m, lc, mc, 1'b1);
    end
    drain();

    // Back-pressure with both stages full.
    lat_mode = 1'b0;
    rand_line(m, lc, mc);
    send(m, lc, mc, 1'b0);
    rand_line(m, lc, mc);
    send(m, lc, mc, 1'b0);
    rand_line(m2, lc2, mc2);
    for (int t = 0; t < 3; t++) begin
      cycle(1'b1, m2, lc2, mc2, 1'b0, acc);
      check("in_ready_stall", MW'(acc), '0);
      check("hold_valid", MW'(out_valid), MW'(1));
      check("hold_lifm", MW'(lifm_vec), MW'(exp_q[0]));
      check("hold_mt", mt_vec, exp_mt_q[0]);
      check("hold_cnt", MW'(nz_cnt), MW'(exp_cnt_q[0]));
    end
    send(m2, lc2, mc2, 1'b1);
    drain();

    // Reset with two lines in flight: nothing from before may emerge.
    rand_line(m, lc, mc);
    send(m | 32'h1, lc, mc, 1'b0);
    rand_line(m, lc, mc);
    send(m | 32'h1, lc, mc, 1'b0);
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", MW'(out_valid), '0);
    check("mid_rst_lifm_vec", MW'(lifm_vec), '0);
    check("mid_rst_mt_vec", mt_vec, '0);
    check("mid_rst_nz_cnt", MW'(nz_cnt), '0);
    check("mid_rst_in_ready", MW'(in_ready), MW'(1));
    exp_q.delete();
    exp_mt_q.delete();
    exp_cnt_q.delete();
    acc_cyc_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    lat_mode = 1'b1;
    for (int t = 0; t < 5; t++) cycle(1'b0, '0, '0, '0, 1'b1, acc);
    rand_line(m, lc, mc);
    send(m, lc, mc, 1'b1);
    drain();

    // Random back-pressure soak for ordering.
    lat_mode = 1'b0;
    for (int n = 0; n < 40; n++) begin
      rand_line(m, lc, mc);
      cycle(1'($urandom_range(0, 1)), m, lc, mc, 1'($urandom_range(0, 1)), acc);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_zv_decompressor

// File: doc/zv_decompressor.md
# zv_decompressor

Zero-value decompressor: the inverse of the zero-value compressor on the LIFM datapath. It accepts a compressed line of nonzero words packed at the low indices, plus a LINE_SIZE-bit nonzero bitmask, and re-expands the line to its original positions, with zeros in every masked-off slot. The per-word mapping-table entries are expanded the same way. It sits between the compressed line buffer and the LIFM consumer, is fully pipelined (two stages, one line per cycle) and uses a valid/ready handshake on both sides.

## Interface
Parameters:
- WORD_WIDTH, 8, bits per LIFM word
- LINE_SIZE, 32, words per line
- DIST_WIDTH, 7, bits per mapping-table distance field
- MAX_LIFM_RSIZ, 3, mapping-table fields per word

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  input line valid
- in_ready  out  1  decompressor can accept a line this cycle
- lifm_comp  in  LINE_SIZE*WORD_WIDTH  packed nonzero words; word k occupies bits [k*WORD_WIDTH +: WORD_WIDTH]
- mt_comp  in  LINE_SIZE*DIST_WIDTH*MAX_LIFM_RSIZ  packed mapping-table entries, same order as lifm_comp
- nz_mask  in  LINE_SIZE  bit i = 1 means original word i is nonzero
- out_valid  out  1  expanded line valid
- out_ready  in  1  consumer accepts the line this cycle
- lifm_vec  out  LINE_SIZE*WORD_WIDTH  expanded line
- mt_vec  out  LINE_SIZE*DIST_WIDTH*MAX_LIFM_RSIZ  expanded mapping table
- nz_cnt  out  $clog2(LINE_SIZE+1)  popcount of nz_mask for the line on the output

## Operation
- Transfer: an input line transfers when in_valid && in_ready; an output line transfers when out_valid && out_ready.
- Stage 1 (S1): registers nz_mask, lifm_comp and mt_comp. Computes and registers the gather index idx[i] = popcount(nz_mask[i-1:0]) (idx[0] = 0), width $clog2(LINE_SIZE). Also registers the total popcount.
- Stage 2 (S2): performs the gather. lifm_vec word i = mask[i] ? lifm_comp word idx[i] : 0. mt_vec entry i follows the same rule. nz_cnt = registered popcount.
- Packed words at positions >= popcount are don't-care. They must never appear on the output.
- Stall logic:
  - s2_load = !s2_valid || out_ready
  - s1_load = !s1_valid || s2_load
  - in_ready = s1_load
  - When a stage does not load, its data and valid hold.
- No reordering and no drops; lines leave in the order they arrived.
- Reset, asynchronous at any time including mid-stream: s1_valid = s2_valid = 0; all data, index and output registers are 0. Consequently out_valid = 0, lifm_vec = 0, mt_vec = 0, nz_cnt = 0, and in_ready = 1 after reset. Lines in flight are discarded.

## Timing
- Latency: a line accepted at edge N is presented with out_valid at edge N+2 when out_ready is held high.
- Throughput: one line per cycle with out_ready constantly high.
- Simultaneous S2 drain and S1 advance in the same cycle is legal and must not create a bubble.
- Outputs are registered. in_ready is combinational from out_ready plus the valid flags; no other combinational input-to-output path exists.
- Under back-pressure, lifm_vec, mt_vec and nz_cnt stay stable while out_valid && !out_ready.

## Configuration
- ZVD_MT_EN defined: the mapping-table path is built as described.
- ZVD_MT_EN undefined:
  - mt_comp is ignored.
  - No mt registers are instantiated.
  - mt_vec is tied to 0.
  - Ports are unchanged. Handshake, latency and lifm behaviour are identical.

## Structure
- Shared package zvc_pkg:
  - default WORD_WIDTH, LINE_SIZE, DIST_WIDTH and MAX_LIFM_RSIZ constants
  - IDX_WIDTH = $clog2(LINE_SIZE) and CNT_WIDTH = $clog2(LINE_SIZE+1)
  - word, mt-entry and index typedefs
  - the package is shared with the compressor
- One sub-module: zv_prefix_count. It is an exclusive prefix popcount over a LINE_SIZE mask that outputs every idx[i] plus the total. It is combinational and reusable by the compressor for its bubble index.
- Top level: pipeline registers, handshake and gather muxes.

## Test plan
- All-ones mask, comp words 0..31 -> lifm_vec word i = i, nz_cnt = 32, out_valid exactly 2 cycles after accept.
- Mask 0, comp filled with 0xFF -> lifm_vec = 0, mt_vec = 0, nz_cnt = 0; stale packed data must not leak.
- Mask 32'h8000_0001, comp word0 = 0xAA, word1 = 0xBB, rest 0x55 -> word0 = 0xAA, word31 = 0xBB, all others 0, nz_cnt = 2; mt entries follow the same positions.
- 8 random lines back-to-back with out_ready = 1 -> 8 outputs on consecutive cycles, in order, each equal to the reference expansion.
- Two lines in flight, out_ready low for 3 cycles:
  - in_ready = 0 while both stages are full
  - output is held stable
  - after release, both lines emerge in order with no duplicate
- reset_n pulsed low with two lines in flight -> immediately out_valid = 0, outputs 0, in_ready = 1 once released; no in-flight line is ever emitted. Rerun the lifm scenarios with ZVD_MT_EN undefined -> mt_vec stays 0.
